// File: rtl/reg_bank_wr_8x16.sv
// reg_bank_wr_8x16
//   Write side of an 8-entry register bank with a sequenced bank-clear.
//   Write select k loads register r(k+1); the register outputs feed the
//   read mux directly, so select k means the same register on both sides.
//   The clear sweep writes CLR_VAL to r1..r8 on eight successive edges.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   D       in   [0:WIDTH-1] write data (bit 0 is MSB)
//   W_sel   in   [0:2] write select, k -> r(k+1)
//   W_en    in   write request
//   clr     in   bank-clear request
//   r1..r8  out  [0:WIDTH-1] register contents (flop outputs)
//   wr_ack  out  high for the cycle following an accepted write
//   busy    out  high while the clear sweep runs
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | accepting writes; clr starts a sweep and drops any coincident write
// CLEAR | writing CLR_VAL to r(idx+1) each edge; W_en and clr ignored

module reg_bank_wr_8x16 #(
   parameter int                 WIDTH   = 16,
   parameter logic [0:WIDTH-1]   CLR_VAL = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [0:WIDTH-1]   D,
   input  logic [0:2]         W_sel,
   input  logic               W_en,
   input  logic               clr,
   output logic [0:WIDTH-1]   r1,
   output logic [0:WIDTH-1]   r2,
   output logic [0:WIDTH-1]   r3,
   output logic [0:WIDTH-1]   r4,
   output logic [0:WIDTH-1]   r5,
   output logic [0:WIDTH-1]   r6,
   output logic [0:WIDTH-1]   r7,
   output logic [0:WIDTH-1]   r8,
   output logic               wr_ack,
   output logic               busy
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [0:WIDTH-1] regs_q [8];
   logic [0:WIDTH-1] regs_d [8];
   logic [0:0]       state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic             busy_q, busy_d;
   logic             ack_q, ack_d;

   always_comb begin
      regs_d  = regs_q;
      state_d = state_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      ack_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clr) begin
               state_d = ST_CLEAR;
               idx_d   = 3'd0;
               busy_d  = 1'b1;
            end else if (W_en) begin
               regs_d[W_sel] = D;
               ack_d         = 1'b1;
            end
         end
         ST_CLEAR: begin
            regs_d[idx_q] = CLR_VAL;
            if (idx_q == 3'd7) begin
               state_d = ST_IDLE;
               idx_d   = 3'd0;
               busy_d  = 1'b0;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = 3'd0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Reset clears to zero rather than CLR_VAL and aborts any sweep in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
         state_q <= ST_IDLE;
         idx_q   <= 3'd0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         regs_q  <= regs_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
      end
   end

   assign r1     = regs_q[0];
   assign r2     = regs_q[1];
   assign r3     = regs_q[2];
   assign r4     = regs_q[3];
   assign r5     = regs_q[4];
   assign r6     = regs_q[5];
   assign r7     = regs_q[6];
   assign r8     = regs_q[7];
   assign wr_ack = ack_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_reg_bank_wr_8x16.sv
module tb_reg_bank_wr_8x16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [0:15] D = '0;
   logic [0:2]  W_sel = '0;
   logic        W_en = 1'b0;
   logic        clr = 1'b0;
   logic [0:15] r [8];
   logic        wr_ack, busy;

   logic [15:0] exp_r [8];
   int checks = 0;
   int failures = 0;

   reg_bank_wr_8x16 #(.WIDTH(16), .CLR_VAL(16'hFFFF)) dut (
      .clk(clk), .rst(rst), .D(D), .W_sel(W_sel), .W_en(W_en), .clr(clr),
      .r1(r[0]), .r2(r[1]), .r3(r[2]), .r4(r[3]),
      .r5(r[4]), .r6(r[5]), .r7(r[6]), .r8(r[7]),
      .wr_ack(wr_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_regs(input string tag);
      for (int i = 0; i < 8; i++)
         chk($sformatf("%s_r%0d", tag, i + 1), r[i], exp_r[i]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;

      // Power-on reset
      tick(); tick();
      rst = 1'b0;
      chk_regs("por");
      chk("por_busy", {15'd0, busy}, 16'd0);
      chk("por_ack", {15'd0, wr_ack}, 16'd0);

      // Load r3 = BEEF, then reset mid-cycle without a clock edge
      W_en = 1'b1; W_sel = 3'd2; D = 16'hBEEF;
      tick();
      W_en = 1'b0;
      exp_r[2] = 16'hBEEF;
      chk("beef_r3", r[2], 16'hBEEF);
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;
      chk_regs("async_rst");
      chk("async_rst_ack", {15'd0, wr_ack}, 16'd0);
      chk("async_rst_busy", {15'd0, busy}, 16'd0);
      rst = 1'b0;

      // Write all eight registers back to back
      for (int k = 0; k < 8; k++) begin
         W_en = 1'b1; W_sel = 3'(k); D = 16'h1111 * 16'(k + 1);
         tick();
         exp_r[k] = 16'h1111 * 16'(k + 1);
         chk($sformatf("wall_ack%0d", k), {15'd0, wr_ack}, 16'd1);
         chk_regs($sformatf("wall%0d", k));
      end
      W_en = 1'b0;
      tick();
      chk("wall_ack_low", {15'd0, wr_ack}, 16'd0);
      chk_regs("wall_hold");

      // Select decode: W_sel=5 -> r6 only; bit 0 is the MSB
      W_en = 1'b1; W_sel = 3'b101; D = 16'h8001;
      tick();
      W_en = 1'b0;
      exp_r[5] = 16'h8001;
      chk_regs("dec");
      chk("dec_ack", {15'd0, wr_ack}, 16'd1);
      chk("dec_r6_bit0", {15'd0, r[5][0]}, 16'd1);
      chk("dec_r6_bit15", {15'd0, r[5][15]}, 16'd1);
      chk("dec_r6_bit1", {15'd0, r[5][1]}, 16'd0);

      // Clear sweep: busy for 8 cycles, registers cleared in order
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_busy_start", {15'd0, busy}, 16'd1);
      chk("clr_ack_start", {15'd0, wr_ack}, 16'd0);
      chk_regs("clr_start");
      for (int i = 0; i < 8; i++) begin
         tick();
         exp_r[i] = 16'hFFFF;
         chk_regs($sformatf("clr_step%0d", i));
         chk($sformatf("clr_busy%0d", i), {15'd0, busy}, (i < 7) ? 16'd1 : 16'd0);
      end

      // Collision: clr with a coincident write drops the write
      W_en = 1'b1; W_sel = 3'd2; D = 16'h5A5A;
      tick();
      exp_r[2] = 16'h5A5A;
      chk("col_pre_r3", r[2], 16'h5A5A);
      clr = 1'b1; W_en = 1'b1; W_sel = 3'd2; D = 16'h1234;
      tick();
      clr = 1'b0; W_en = 1'b0;
      chk_regs("col_start");
      chk("col_ack", {15'd0, wr_ack}, 16'd0);
      chk("col_busy", {15'd0, busy}, 16'd1);
      for (int i = 0; i < 8; i++) begin
         clr  = (i == 2 || i == 7);
         W_en = (i == 3 || i == 5 || i == 7);
         W_sel = 3'd0; D = 16'h0BAD;
         tick();
         exp_r[i] = 16'hFFFF;
         chk($sformatf("col_sw_ack%0d", i), {15'd0, wr_ack}, 16'd0);
         chk($sformatf("col_sw_busy%0d", i), {15'd0, busy}, (i < 7) ? 16'd1 : 16'd0);
      end
      clr = 1'b0; W_en = 1'b0;
      chk_regs("col_end");
      tick();
      chk("col_norestart_busy", {15'd0, busy}, 16'd0);
      chk("col_norestart_ack", {15'd0, wr_ack}, 16'd0);
      W_en = 1'b1; W_sel = 3'd0; D = 16'hABCD;
      tick();
      W_en = 1'b0;
      exp_r[0] = 16'hABCD;
      chk_regs("post_clr_wr");
      chk("post_clr_ack", {15'd0, wr_ack}, 16'd1);

      // Reset mid-sweep: sweep aborted, all zero, next write accepted
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick(); tick(); tick();
      exp_r[0] = 16'hFFFF;
      chk("msw_r1_cleared", r[0], 16'hFFFF);
      chk("msw_busy", {15'd0, busy}, 16'd1);
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;
      chk_regs("msw_rst");
      chk("msw_rst_busy", {15'd0, busy}, 16'd0);
      chk("msw_rst_ack", {15'd0, wr_ack}, 16'd0);
      rst = 1'b0;
      W_en = 1'b1; W_sel = 3'd4; D = 16'h0F0F;
      tick();
      W_en = 1'b0;
      exp_r[4] = 16'h0F0F;
      chk_regs("msw_wr");
      chk("msw_wr_ack", {15'd0, wr_ack}, 16'd1);
      chk("msw_wr_busy", {15'd0, busy}, 16'd0);
      tick();
      chk_regs("msw_hold");
      chk("msw_hold_ack", {15'd0, wr_ack}, 16'd0);
      chk("msw_hold_busy", {15'd0, busy}, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
